mux2to1_32bit: RTL and testbench
================================

// Module: mux2to1_32bit
// PURPOSE
//   Two-input, 32-bit word selector for the datapath (operand/writeback select).
//   Primary output `out` is purely combinational: zero latency, no clock needed.
//   Registered copy, parity and select-toggle statistics are provided for
//   pipelined consumers and debug.
//   One clock; the asynchronous active-low reset affects only registered state.
// PARAMETERS
//   WIDTH      32   data word width in bits; out/out_q follow it
//   CNT_W      16   width of the select-toggle counter
// PORTS
//   clk          in   1        system clock, rising edge
//   rst_n        in   1        asynchronous active-low reset
//   data0        in   WIDTH    word passed when select = 0
//   data1        in   WIDTH    word passed when select = 1
//   select       in   1        0 -> data0, 1 -> data1
//   out          out  WIDTH    combinational selected word
//   out_par      out  1        combinational even parity (XOR-reduce) of out
//   out_q        out  WIDTH    out registered on rising clk
//   toggle_cnt   out  CNT_W    number of sampled select changes, saturating
// BEHAVIOUR
//   - out = select ? data1 : data0, continuous assignment; settles within the
//     same delta/timestep as any input change; independent of clk and rst_n.
//   - out must be valid even if clk never toggles and rst_n is never driven.
//   - select X/Z: bits where data0 == data1 output that value; other bits X
//     (standard ?: merge); no silent pick of either input.
//   - out_par = ^out, combinational.
//   - Reset (rst_n = 0, asynchronous, immediate): out_q = 0, toggle_cnt = 0,
//     internal sel_prev = 0. Deassertion takes effect at the next rising clk.
//   - Each rising clk with rst_n = 1: out_q <= out (1-cycle latency);
//     sel_prev <= select; if select != sel_prev and toggle_cnt != all-ones,
//     toggle_cnt <= toggle_cnt + 1; at all-ones it holds (no wrap).
//   - First clock after reset with select = 1 counts as a toggle (sel_prev = 0).
//   - Reset mid-operation: registered outputs clear at once; out unaffected.
//   - No handshake; no state machine; inputs sampled every cycle.
// STRUCTURE
//   - Package mux_pkg: WIDTH and CNT_W default localparams; typedef
//     logic [WIDTH-1:0] word_t shared with datapath users.
//   - Sub-module mux_stat_reg: out_q register, sel_prev and saturating
//     counter, all on clk/rst_n; the top holds only the combinational select
//     and parity logic.
//   - Synthesis must infer a single LUT/mux level for out; no latches.
// TESTING
//   1. No clock: data0=ABCDEFFA, data1=12345678, select=0 -> out=ABCDEFFA,
//      out_par=^ABCDEFFA.
//   2. No clock: data0=ABCDEF12, data1=98765432, select=1, wait 10 ->
//      out=98765432.
//   3. rst_n=0 with clk running -> out_q=0, toggle_cnt=0 immediately; release,
//      data1=98765432, select=1, one edge -> out_q=98765432, toggle_cnt=1.
//   4. Toggle select every cycle for 70000 cycles -> toggle_cnt sticks at FFFF.
//   5. select=X, data0=data1=5A5A5A5A -> out=5A5A5A5A; data1=5A5A5A5B ->
//      bit0 X.
//   6. Assert rst_n low between edges mid-stream -> out_q, toggle_cnt zero
//      without waiting for clk; out still tracks inputs.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared widths and word types for the 2:1 word selector and its datapath users.
package mux_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/mux2to1_32bit_if.sv
// Signal bundle for the word selector: master drives data/select, slave returns results.
interface mux2to1_32bit_if;
  import mux_pkg::*;

  // No handshake: inputs are sampled every cycle and outputs are always valid.
  word_t data0;
  word_t data1;
  logic  select;
  word_t out;
  logic  out_par;
  word_t out_q;
  cnt_t  toggle_cnt;

  modport master (
    output data0, data1, select,
    input  out, out_par, out_q, toggle_cnt
  );

  modport slave (
    input  data0, data1, select,
    output out, out_par, out_q, toggle_cnt
  );
endinterface

// File: rtl/mux_stat_reg.sv
// Registered copy of the selected word plus a saturating count of select changes.
module mux_stat_reg
  import mux_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  word_t d,
  input  logic  select,
  output word_t q,
  output cnt_t  toggle_cnt
);
  localparam cnt_t CNT_MAX = '1;

  logic sel_prev;

  // sel_prev clears to 0, so a first post-reset cycle with select=1 counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q          <= '0;
      sel_prev   <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      q        <= d;
      sel_prev <= select;
      if ((select != sel_prev) && (toggle_cnt != CNT_MAX))
        toggle_cnt <= toggle_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mux2to1_32bit.sv
// 2:1 word selector: combinational out/parity, registered copy and toggle statistics.
module mux2to1_32bit
  import mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mux2to1_32bit_if.slave    bus
);
  word_t sel_word;

  // Plain ?: so an unknown select merges the inputs rather than picking one.
  assign sel_word    = bus.select ? bus.data1 : bus.data0;
  assign bus.out     = sel_word;
  assign bus.out_par = ^sel_word;

  mux_stat_reg u_stat (
    .clk        (clk),
    .rst_n      (rst_n),
    .d          (sel_word),
    .select     (bus.select),
    .q          (bus.out_q),
    .toggle_cnt (bus.toggle_cnt)
  );
endmodule

// File: tb/tb_mux2to1_32bit.sv
// Directed bench for mux2to1_32bit: expectations queued by the driver, drained by a monitor.
module tb_mux2to1_32bit;
  localparam int W = 32;
  localparam int K_OUT  = 0;
  localparam int K_PAR  = 1;
  localparam int K_OUTQ = 2;
  localparam int K_CNT  = 3;

  logic clk;
  logic clk_en;
  logic rst_n;

  mux2to1_32bit_if bus ();

  mux2to1_32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk    = 1'b0;
    clk_en = 1'b0;
    rst_n  = 1'b1;
  end

  always #5 if (clk_en) clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           kind_q[$];
  string        name_q[$];
  event         chk_ev;
  int           checks = 0;
  int           errors = 0;

  task automatic expect_val(input int kind, input string name,
                            input logic [W-1:0] exp, input logic [W-1:0] mask);
    exp_q.push_back(exp);
    mask_q.push_back(mask);
    kind_q.push_back(kind);
    name_q.push_back(name);
  endtask

  task automatic sample();
    -> chk_ev;
    #1;
  endtask

  initial begin
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        logic [W-1:0] e, m, a;
        int           k;
        string        n;
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        k = kind_q.pop_front();
        n = name_q.pop_front();
        case (k)
          K_OUT:   a = bus.out;
          K_PAR:   a = {{(W-1){1'b0}}, bus.out_par};
          K_OUTQ:  a = bus.out_q;
          default: a = {{(W-16){1'b0}}, bus.toggle_cnt};
        endcase
        checks++;
        if ((a & m) !== (e & m)) begin
          errors++;
          $display("FAIL %s: got %h, expected %h (mask %h)", n, a, e, m);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic toggle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.select = ~bus.select;
      @(posedge clk);
    end
    #1;
  endtask

  localparam logic [W-1:0] ALL = 32'hFFFF_FFFF;

  initial begin
    // 1. no clock, select=0
    bus.data0  = 32'hABCD_EFFA;
    bus.data1  = 32'h1234_5678;
    bus.select = 1'b0;
    #1;
    expect_val(K_OUT, "nclk_sel0_out", 32'hABCD_EFFA, ALL);
    expect_val(K_PAR, "nclk_sel0_par", 32'h1, ALL);
    sample();

    // 2. no clock, select=1
    bus.data0  = 32'hABCD_EF12;
    bus.data1  = 32'h9876_5432;
    bus.select = 1'b1;
    #10;
    expect_val(K_OUT, "nclk_sel1_out", 32'h9876_5432, ALL);
    expect_val(K_PAR, "nclk_sel1_par", 32'h0, ALL);
    sample();

    // 5. unknown select: equal inputs pass through, differing bit is not checked
    bus.select = 1'bx;
    bus.data0  = 32'h5A5A_5A5A;
    bus.data1  = 32'h5A5A_5A5A;
    #1;
    expect_val(K_OUT, "selx_equal_out", 32'h5A5A_5A5A, ALL);
    expect_val(K_PAR, "selx_equal_par", 32'h0, ALL);
    sample();
    bus.data1 = 32'h5A5A_5A5B;
    #1;
    expect_val(K_OUT, "selx_diff_upper", 32'h5A5A_5A5A, 32'hFFFF_FFFE);
    sample();

    // 3. reset with clock running, then release
    bus.select = 1'b1;
    bus.data0  = 32'hABCD_EF12;
    bus.data1  = 32'h9876_5432;
    clk_en = 1'b1;
    rst_n  = 1'b0;
    #1;
    expect_val(K_OUTQ, "rst_outq", 32'h0, ALL);
    expect_val(K_CNT,  "rst_cnt",  32'h0, ALL);
    sample();
    repeat (2) @(posedge clk);
    #1;
    expect_val(K_OUTQ, "rst_hold_outq", 32'h0, ALL);
    expect_val(K_CNT,  "rst_hold_cnt",  32'h0, ALL);
    sample();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expect_val(K_OUTQ, "first_edge_outq", 32'h9876_5432, ALL);
    expect_val(K_CNT,  "first_edge_cnt",  32'h1, ALL);
    sample();

    // steady select: no count
    @(posedge clk);
    #1;
    expect_val(K_CNT, "steady_cnt", 32'h1, ALL);
    sample();

    // change select between edges: out immediate, out_q one edge later
    @(negedge clk);
    bus.select = 1'b0;
    #1;
    expect_val(K_OUT,  "sel0_out_now",   32'hABCD_EF12, ALL);
    expect_val(K_OUTQ, "sel0_outq_prev", 32'h9876_5432, ALL);
    sample();
    @(posedge clk);
    #1;
    expect_val(K_OUTQ, "sel0_outq_next", 32'hABCD_EF12, ALL);
    expect_val(K_CNT,  "sel0_cnt",       32'h2, ALL);
    sample();

    // 4. toggle every cycle: 2 + 10 = 12, then saturate at FFFF
    toggle_cycles(10);
    expect_val(K_CNT,  "tog10_cnt",  32'hC, ALL);
    expect_val(K_OUTQ, "tog10_outq", 32'hABCD_EF12, ALL);
    sample();
    toggle_cycles(69990);
    expect_val(K_CNT,  "tog_sat_cnt",  32'hFFFF, ALL);
    expect_val(K_OUTQ, "tog_sat_outq", 32'hABCD_EF12, ALL);
    sample();
    toggle_cycles(1);
    expect_val(K_CNT,  "tog_nowrap_cnt",  32'hFFFF, ALL);
    expect_val(K_OUTQ, "tog_nowrap_outq", 32'h9876_5432, ALL);
    sample();

    // 6. reset between edges mid-stream
    #1;
    rst_n = 1'b0;
    #1;
    expect_val(K_OUTQ, "mid_rst_outq", 32'h0, ALL);
    expect_val(K_CNT,  "mid_rst_cnt",  32'h0, ALL);
    expect_val(K_OUT,  "mid_rst_out",  32'h9876_5432, ALL);
    sample();
    bus.data0  = 32'h0000_0007;
    bus.select = 1'b0;
    #1;
    expect_val(K_OUT, "mid_rst_track_out", 32'h0000_0007, ALL);
    expect_val(K_PAR, "mid_rst_track_par", 32'h1, ALL);
    sample();
    @(posedge clk);
    #1;
    expect_val(K_OUTQ, "mid_rst_hold_outq", 32'h0, ALL);
    expect_val(K_CNT,  "mid_rst_hold_cnt",  32'h0, ALL);
    sample();
    @(negedge clk);
    rst_n      = 1'b1;
    bus.select = 1'b1;
    @(posedge clk);
    #1;
    expect_val(K_OUTQ, "post_rst_outq", 32'h9876_5432, ALL);
    expect_val(K_CNT,  "post_rst_cnt",  32'h1, ALL);
    sample();

    clk_en = 1'b0;
    #5;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
